// File: rtl/sar_adc_controller_pkg.sv
// Shared types and defaults for the SAR ADC controller and its bench model.
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        TRIAL  = 2'd2,
        DONE   = 2'd3
    } sar_state_t;

    localparam int SAR_N_BITS         = 8;
    localparam int SAR_SAMPLE_CYCLES  = 4;
    localparam int SAR_SETTLE_CYCLES  = 1;

    // Counter width able to hold v, never narrower than one bit.
    function automatic int sar_width_for(input int v);
        return (v < 2) ? 1 : $clog2(v + 1);
    endfunction

endpackage

// File: rtl/sar_adc_controller_cycle_timer.sv
// Loadable down-counter with a zero flag; times both the track window and
// the per-bit DAC settle window.
module sar_cycle_timer #(
    parameter int W = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    // Load takes priority; otherwise count down and park at zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/sar_adc_controller.sv
// SAR ADC sequencer: track/hold control, MSB-first binary search on the
// capacitive DAC code, result capture with a one-cycle done strobe.
//
// state  | meaning
// IDLE   | waiting for start; S&H in hold, DAC code zero
// SAMPLE | S&H tracking for SAMPLE_CYCLES cycles
// TRIAL  | one trial bit on the DAC, settling, then comparator decision
// DONE   | one cycle; result valid, done high
module sar_adc_controller
    import sar_pkg::*;
#(
    parameter int N_BITS        = SAR_N_BITS,
    parameter int SAMPLE_CYCLES = SAR_SAMPLE_CYCLES,
    parameter int SETTLE_CYCLES = SAR_SETTLE_CYCLES
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_cont_mode,
    input  logic              i_abort,
    input  logic              i_comp_in,
    output logic              o_sh_sample,
    output logic [N_BITS-1:0] o_dac_code,
    output logic              o_busy,
    output logic              o_done,
    output logic [N_BITS-1:0] o_result,
    output logic              o_overrun
);

    localparam int TMAX = (SAMPLE_CYCLES - 1 > SETTLE_CYCLES) ? SAMPLE_CYCLES - 1 : SETTLE_CYCLES;
    localparam int TW   = sar_width_for(TMAX);
    localparam int KW   = sar_width_for(N_BITS - 1);
    localparam logic [N_BITS-1:0] ONE_CODE = N_BITS'(1);
    localparam logic [N_BITS-1:0] MSB_CODE = ONE_CODE << (N_BITS - 1);

    sar_state_t        r_state;
    logic              r_sh_sample;
    logic [N_BITS-1:0] r_dac_code;
    logic              r_busy;
    logic              r_done;
    logic [N_BITS-1:0] r_result;
    logic              r_overrun;
    logic [KW-1:0]     r_bit_idx;

    logic              w_tmr_load;
    logic [TW-1:0]     w_tmr_val;
    logic              w_tmr_zero;
    logic [N_BITS-1:0] w_bit_mask;
    logic [N_BITS-1:0] w_decided;
    logic [N_BITS-1:0] w_trial_next;

    sar_cycle_timer #(.W(TW)) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero     (w_tmr_zero)
    );

    // Current bit decision and the next trial code (next lower bit set).
    always_comb begin
        w_bit_mask   = ONE_CODE << r_bit_idx;
        w_decided    = i_comp_in ? r_dac_code : (r_dac_code & ~w_bit_mask);
        w_trial_next = w_decided | (w_bit_mask >> 1);
    end

    // Timer reload whenever a new track or settle window begins.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = TW'(SAMPLE_CYCLES - 1);
        case (r_state)
            IDLE:   w_tmr_load = i_start;
            SAMPLE: begin
                w_tmr_load = !i_abort && w_tmr_zero;
                w_tmr_val  = TW'(SETTLE_CYCLES);
            end
            TRIAL:  begin
                w_tmr_load = !i_abort && w_tmr_zero && (r_bit_idx != '0);
                w_tmr_val  = TW'(SETTLE_CYCLES);
            end
            DONE:   w_tmr_load = i_cont_mode || i_start;
            default: w_tmr_load = 1'b0;
        endcase
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_sh_sample <= 1'b0;
            r_dac_code  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_overrun   <= 1'b0;
            r_bit_idx   <= '0;
        end else begin
            r_done <= 1'b0;
            // A start while a conversion is still running is lost; flag it.
            if ((r_state == SAMPLE || r_state == TRIAL) && i_start) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state     <= SAMPLE;
                        r_sh_sample <= 1'b1;
                        r_busy      <= 1'b1;
                        r_dac_code  <= '0;
                    end
                end
                SAMPLE: begin
                    if (i_abort) begin
                        r_state     <= IDLE;
                        r_sh_sample <= 1'b0;
                        r_dac_code  <= '0;
                        r_busy      <= 1'b0;
                    end else if (w_tmr_zero) begin
                        r_state     <= TRIAL;
                        r_sh_sample <= 1'b0;
                        r_bit_idx   <= KW'(N_BITS - 1);
                        r_dac_code  <= MSB_CODE;
                    end
                end
                TRIAL: begin
                    if (i_abort) begin
                        r_state     <= IDLE;
                        r_dac_code  <= '0;
                        r_busy      <= 1'b0;
                    end else if (w_tmr_zero) begin
                        if (r_bit_idx != '0) begin
                            r_dac_code <= w_trial_next;
                            r_bit_idx  <= r_bit_idx - KW'(1);
                        end else begin
                            r_state    <= DONE;
                            r_dac_code <= w_decided;
                            r_result   <= w_decided;
                            r_done     <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_dac_code <= '0;
                    if (i_cont_mode || i_start) begin
                        r_state     <= SAMPLE;
                        r_sh_sample <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_sh_sample = r_sh_sample;
    assign o_dac_code  = r_dac_code;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_result    = r_result;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_sar_adc_controller.sv
// Directed bench for sar_adc_controller at default parameters.
module tb_sar_adc_controller;
    import sar_pkg::*;

    localparam int NB  = SAR_N_BITS;
    localparam int LAT = 4 + 8 * 2;   // done cycle at defaults

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          cont_mode = 1'b0;
    logic          abort = 1'b0;
    logic          comp_in;
    logic          sh_sample;
    logic [NB-1:0] dac_code;
    logic          busy;
    logic          done;
    logic [NB-1:0] result;
    logic          overrun;
    logic [NB-1:0] model_vin = '0;

    int errors = 0;
    int checks = 0;

    sar_adc_controller dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_cont_mode (cont_mode),
        .i_abort     (abort),
        .i_comp_in   (comp_in),
        .o_sh_sample (sh_sample),
        .o_dac_code  (dac_code),
        .o_busy      (busy),
        .o_done      (done),
        .o_result    (result),
        .o_overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Comparator model: 1 when the held input is at or above the DAC level.
    assign comp_in = (model_vin >= dac_code);

    // Trial code expected while bit k is under test for input vin.
    function automatic logic [7:0] exp_trial(input logic [7:0] vin, input int k);
        logic [7:0] hi;
        logic [7:0] one;
        hi  = 8'hFF;
        hi  = hi << (k + 1);
        one = 8'h01;
        return (vin & hi) | (one << k);
    endfunction

    // Pulse start for one cycle; returns at the negedge of cycle 0.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        @(negedge clk);
        checks++; if (sh_sample !== 1'b0) begin errors++; $display("FAIL reset_sh: got %b want 0", sh_sample); end
        checks++; if (dac_code !== 8'h00) begin errors++; $display("FAIL reset_dac: got %h want 00", dac_code); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result: got %h want 00", result); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        model_vin = 8'hA5;
        pulse_start();
        for (int c = 0; c < LAT + 3; c++) begin
            checks++;
            if (sh_sample !== (c < 4)) begin errors++; $display("FAIL basic_sh c=%0d: got %b want %b", c, sh_sample, (c < 4)); end
            if (c >= 4 && c < LAT) begin
                checks++;
                if (dac_code !== exp_trial(8'hA5, 7 - (c - 4) / 2)) begin
                    errors++; $display("FAIL basic_dac c=%0d: got %h want %h", c, dac_code, exp_trial(8'hA5, 7 - (c - 4) / 2));
                end
            end
            checks++;
            if (done !== (c == LAT)) begin errors++; $display("FAIL basic_done c=%0d: got %b want %b", c, done, (c == LAT)); end
            checks++;
            if (busy !== (c <= LAT)) begin errors++; $display("FAIL basic_busy c=%0d: got %b want %b", c, busy, (c <= LAT)); end
            if (c == LAT) begin
                checks++;
                if (result !== 8'hA5) begin errors++; $display("FAIL basic_result: got %h want a5", result); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_boundary();
        logic [7:0] vins [2];
        bit seen;
        vins[0] = 8'h00;
        vins[1] = 8'hFF;
        for (int v = 0; v < 2; v++) begin
            model_vin = vins[v];
            pulse_start();
            seen = 1'b0;
            for (int c = 0; c < 40 && !seen; c++) begin
                if (done === 1'b1) begin
                    seen = 1'b1;
                    checks++;
                    if (c != LAT) begin errors++; $display("FAIL bound_lat vin=%h: got %0d want %0d", vins[v], c, LAT); end
                    checks++;
                    if (result !== vins[v]) begin errors++; $display("FAIL bound_result: got %h want %h", result, vins[v]); end
                end
                @(negedge clk);
            end
            checks++;
            if (!seen) begin errors++; $display("FAIL bound_timeout vin=%h: got no done want done", vins[v]); end
            checks++;
            if (overrun !== 1'b0) begin errors++; $display("FAIL bound_overrun: got %b want 0", overrun); end
            @(negedge clk);
        end
    endtask

    task automatic test_cont();
        bit idle;
        model_vin = 8'h3C;
        cont_mode = 1'b1;
        pulse_start();
        for (int c = 0; c < 70; c++) begin
            checks++;
            if (done !== ((c % 21) == 20)) begin errors++; $display("FAIL cont_done c=%0d: got %b want %b", c, done, ((c % 21) == 20)); end
            if ((c % 21) == 20) begin
                checks++;
                if (result !== 8'h3C) begin errors++; $display("FAIL cont_result c=%0d: got %h want 3c", c, result); end
            end
            if ((c % 21) == 0) begin
                checks++;
                if (sh_sample !== 1'b1) begin errors++; $display("FAIL cont_sh c=%0d: got %b want 1", c, sh_sample); end
            end
            @(negedge clk);
        end
        cont_mode = 1'b0;
        idle = 1'b0;
        for (int c = 0; c < 50 && !idle; c++) begin
            @(negedge clk);
            idle = (busy === 1'b0);
        end
        checks++;
        if (!idle) begin errors++; $display("FAIL cont_stop: got busy want idle"); end
    endtask

    task automatic test_abort();
        model_vin = 8'hA5;
        pulse_start();
        repeat (LAT + 2) @(negedge clk);
        checks++;
        if (result !== 8'hA5) begin errors++; $display("FAIL abort_pre_result: got %h want a5", result); end
        model_vin = 8'h12;
        pulse_start();
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++; if (dac_code !== 8'h00) begin errors++; $display("FAIL abort_dac: got %h want 00", dac_code); end
        checks++; if (sh_sample !== 1'b0) begin errors++; $display("FAIL abort_sh: got %b want 0", sh_sample); end
        for (int c = 0; c < 25; c++) begin
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_quiet c=%0d: got done=%b busy=%b want 0 0", c, done, busy); end
            @(negedge clk);
        end
        checks++;
        if (result !== 8'hA5) begin errors++; $display("FAIL abort_result: got %h want a5", result); end
    endtask

    task automatic test_overrun();
        model_vin = 8'hA5;
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_pre: got %b want 0", overrun); end
        pulse_start();
        for (int c = 0; c < LAT + 12; c++) begin
            start = (c == 10);
            if (c >= 11) begin
                checks++;
                if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky c=%0d: got %b want 1", c, overrun); end
            end
            checks++;
            if (done !== (c == LAT)) begin errors++; $display("FAIL ovr_done c=%0d: got %b want %b", c, done, (c == LAT)); end
            checks++;
            if (busy !== (c <= LAT)) begin errors++; $display("FAIL ovr_busy c=%0d: got %b want %b", c, busy, (c <= LAT)); end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (result !== 8'hA5) begin errors++; $display("FAIL ovr_result: got %h want a5", result); end
    endtask

    task automatic test_rst_mid();
        bit seen;
        model_vin = 8'h5A;
        pulse_start();
        repeat (8) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (sh_sample !== 1'b0 || dac_code !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || result !== 8'h00 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: got sh=%b dac=%h busy=%b done=%b res=%h ovr=%b want all 0", sh_sample, dac_code, busy, done, result, overrun);
        end
        @(negedge clk);
        rst = 1'b0;
        pulse_start();
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (c != LAT) begin errors++; $display("FAIL rst_lat: got %0d want %0d", c, LAT); end
                checks++;
                if (result !== 8'h5A) begin errors++; $display("FAIL rst_result: got %h want 5a", result); end
            end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rst_timeout: got no done want done"); end
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b want 0", overrun); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_cont();
        test_abort();
        test_overrun();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sar_adc_controller.md
Name: sar_adc_controller

Overview:
- Sequencer for the SAR ADC built around the Sample_and_Hold analog macro.
- Drives the S&H track/hold switch and runs an N-bit binary search on a capacitive DAC code, one trial bit at a time.
- Reads the external comparator and presents the result with a one-cycle done strobe.
- Sits between the tt_um top level (digital pins) and the analog S&H/DAC/comparator on ua[].

Parameters:
- N_BITS, 8, conversion resolution; width of dac_code and result.
- SAMPLE_CYCLES, 4, cycles sh_sample is held high (track) per conversion; minimum 1.
- SETTLE_CYCLES, 1, extra DAC settling cycles per trial bit before comp_in is sampled; 0 allowed.

Ports:
- clk  in  1  system clock (codebase clock name).
- rst  in  1  reset: asynchronous, active-high. All state clears immediately on assertion.
- start  in  1  conversion request; level-sampled in IDLE.
- cont_mode  in  1  1 = back-to-back conversions without further start.
- abort  in  1  synchronous abort of the conversion in progress.
- comp_in  in  1  comparator output, already synchronised upstream; 1 = Vin >= Vdac.
- sh_sample  out  1  1 = S&H tracking, 0 = hold.
- dac_code  out  N_BITS  trial code to the DAC.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when result updates.
- result  out  N_BITS  last completed conversion; holds until the next done.
- overrun  out  1  sticky; set if start=1 while busy and DONE is not the current state. Cleared only by rst.

Behaviour:
- Reset values: sh_sample=0, dac_code=0, busy=0, done=0, result=0, overrun=0, state=IDLE, counters=0.
- States: IDLE, SAMPLE, TRIAL, DONE.
- IDLE:
  - sh_sample=0, dac_code=0.
  - start=1 at a rising edge -> SAMPLE; sample counter loaded.
- SAMPLE:
  - sh_sample=1 for exactly SAMPLE_CYCLES cycles.
  - On leaving: bit index k=N_BITS-1, dac_code = 1<<k, -> TRIAL.
- TRIAL:
  - sh_sample=0.
  - Trial code held for SETTLE_CYCLES+1 cycles.
  - On the last edge: bit k is kept if comp_in=1, cleared if comp_in=0.
  - If k>0: k decrements and bit k-1 is set in the same edge.
  - If k=0 -> DONE.
- DONE:
  - One cycle; done=1; result = final code (registered on the entering edge, visible while done=1).
  - Next state: cont_mode=1 -> SAMPLE; else IDLE.
  - start in DONE is honoured exactly like cont_mode: -> SAMPLE, no overrun.
- Latency: numbering the first SAMPLE cycle as 0, done is high in cycle SAMPLE_CYCLES + N_BITS*(SETTLE_CYCLES+1). Defaults give 20.
- Conversion period in continuous mode: SAMPLE_CYCLES + N_BITS*(SETTLE_CYCLES+1) + 1 cycles.
- abort=1 in SAMPLE or TRIAL:
  - Next edge -> IDLE; dac_code=0.
  - No done pulse; result unchanged.
  - abort takes priority over trial decision and over cont_mode.
  - abort is ignored in IDLE and DONE.
- start while busy (not in DONE): ignored for sequencing; sets overrun.
- Boundary codes:
  - comp_in always 1 -> result all ones.
  - comp_in always 0 -> result 0.
  - No wrap or overflow is possible; dac_code is at most all ones.
- rst mid-conversion: outputs return to reset values asynchronously; no done pulse.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package sar_pkg:
  - state enum sar_state_t (IDLE, SAMPLE, TRIAL, DONE).
  - default N_BITS constant, shared with the top level and the bench comparator model.
- One sub-module: sar_cycle_timer, a loadable down-counter with a zero flag, used for both the SAMPLE and settle windows.
- Bit index and successive-approximation register live in the controller.

Test Plan:
- Defaults; comparator model comp_in = (0xA5 >= dac_code); start pulse -> sh_sample high cycles 0-3; dac_code 0x80 in cycles 4-5, then 0xC0, 0xA0, ...; done in cycle 20 only; result=0xA5; busy low in cycle 21.
- Model inputs 0x00 and 0xFF -> result 0x00 and 0xFF respectively; no overrun.
- cont_mode=1, model input 0x3C -> done pulses exactly every 21 cycles; result=0x3C each time; sh_sample re-asserts the cycle after each done.
- abort asserted in trial cycle 9 -> IDLE next cycle; dac_code=0; no done; result keeps its prior value 0xA5.
- start re-pulsed in cycle 10 of a conversion -> overrun=1 and stays set; the conversion completes normally with done in cycle 20; no second conversion starts.
- rst asserted asynchronously mid-TRIAL -> all outputs 0 before the next clk edge; after release, a start produces a clean conversion.
